// File: rtl/riscv_pkg.sv
// Shared encodings for the barrel core execute stage: ALU ops, branch and RV32M funct3 codes,
// and the execute FSM state type.
package riscv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic {IDLE, DIV_BUSY} ex_state_t;

endpackage

// File: rtl/execute_md_mt_if.sv
// Decode->execute handshake and execute->memory boundary signals of the execute stage.
interface execute_md_mt_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned NUM_THREADS   = 4
);
    localparam int unsigned BITS_THREADS = $clog2(NUM_THREADS);

    logic                     valid_d, ready_d;
    logic                     reg_write_d, mem_write_d, jump_d, branch_d, md_en_d;
    logic [1:0]               res_src_d;
    logic [3:0]               alu_control_d;
    logic [2:0]               funct3_d;
    logic                     alu_src_a_d, alu_src_b_d;
    logic [DATA_WIDTH-1:0]    rd1_d, rd2_d, imm_val_d;
    logic [ADDRESS_WIDTH-1:0] pc_d, pc_plus4_d;
    logic [4:0]               rd_d;
    logic [BITS_THREADS-1:0]  tid_d;

    logic                     valid_e, reg_write_e, mem_write_e, pc_src_e;
    logic [1:0]               res_src_e;
    logic [2:0]               funct3_e;
    logic [4:0]               rd_e;
    logic [BITS_THREADS-1:0]  tid_e;
    logic [DATA_WIDTH-1:0]    alu_result_e, write_data_e;
    logic [ADDRESS_WIDTH-1:0] pc_target_e, pc_plus4_e;

    modport master (
        output valid_d, reg_write_d, mem_write_d, jump_d, branch_d, md_en_d, res_src_d,
               alu_control_d, funct3_d, alu_src_a_d, alu_src_b_d, rd1_d, rd2_d, imm_val_d,
               pc_d, pc_plus4_d, rd_d, tid_d,
        input  ready_d, valid_e, reg_write_e, mem_write_e, pc_src_e, res_src_e, funct3_e,
               rd_e, tid_e, alu_result_e, write_data_e, pc_target_e, pc_plus4_e
    );

    modport slave (
        input  valid_d, reg_write_d, mem_write_d, jump_d, branch_d, md_en_d, res_src_d,
               alu_control_d, funct3_d, alu_src_a_d, alu_src_b_d, rd1_d, rd2_d, imm_val_d,
               pc_d, pc_plus4_d, rd_d, tid_d,
        output ready_d, valid_e, reg_write_e, mem_write_e, pc_src_e, res_src_e, funct3_e,
               rd_e, tid_e, alu_result_e, write_data_e, pc_target_e, pc_plus4_e
    );
endinterface

// File: rtl/execute_md_mt_div.sv
// Radix-2 restoring divider on operand magnitudes, one quotient bit per cycle, signs fixed
// up on the final result. done is high for the one cycle after the last iteration.
module md_divider #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_signed,
    input  logic                  i_rem,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);
    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

    logic                  r_busy, r_neg_q, r_neg_r, r_sel_rem;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_quo, r_rem, r_div;
    logic [DATA_WIDTH:0]   w_shift, w_diff;
    logic [DATA_WIDTH-1:0] w_abs_a, w_abs_b, w_q, w_r;

    assign w_abs_a = (i_signed && i_dividend[DATA_WIDTH-1]) ? -i_dividend : i_dividend;
    assign w_abs_b = (i_signed && i_divisor[DATA_WIDTH-1])  ? -i_divisor  : i_divisor;

    // Partial remainder needs one extra bit: the shifted value can reach 2*divisor-1.
    assign w_shift = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    assign o_busy   = r_busy;
    assign o_done   = r_busy && (r_cnt == CW'(DATA_WIDTH));
    assign w_q      = r_neg_q ? -r_quo : r_quo;
    assign w_r      = r_neg_r ? -r_rem : r_rem;
    assign o_result = r_sel_rem ? w_r : w_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_sel_rem <= 1'b0;
        end else if (i_start) begin
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_quo     <= w_abs_a;
            r_rem     <= '0;
            r_div     <= w_abs_b;
            r_neg_q   <= i_signed && (i_dividend[DATA_WIDTH-1] ^ i_divisor[DATA_WIDTH-1]);
            r_neg_r   <= i_signed && i_dividend[DATA_WIDTH-1];
            r_sel_rem <= i_rem;
        end else if (r_busy) begin
            if (o_done) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                r_rem <= w_diff[DATA_WIDTH] ? w_shift[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
                r_quo <= {r_quo[DATA_WIDTH-2:0], ~w_diff[DATA_WIDTH]};
            end
        end
    end
endmodule

// File: rtl/execute_md_mt.sv
// Registered execute stage: ALU, branch resolution, single-cycle RV32M multiply and a
// multi-cycle divider that stalls decode via ready_d.
module execute_md_mt
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned NUM_THREADS   = 4
) (
    input logic            clk,
    input logic            rst,
    execute_md_mt_if.slave bus
);
    localparam int unsigned BITS_THREADS = $clog2(NUM_THREADS);
    localparam int unsigned SHW = $clog2(DATA_WIDTH);
    localparam int unsigned PW  = 2 * DATA_WIDTH + 2;

    ex_state_t             r_state;
    logic                  w_transfer, w_taken, w_div_op, w_div_signed, w_div_zero, w_div_ovf;
    logic                  w_div_start, w_div_busy, w_div_done;
    logic [DATA_WIDTH-1:0] w_src_a, w_src_b, w_alu, w_md, w_result, w_div_result, w_min;
    logic [SHW-1:0]        w_shamt;
    logic [PW-1:0]         w_mul_a, w_mul_b, w_prod;

    assign bus.ready_d = (r_state == IDLE);
    assign w_transfer  = bus.valid_d && (r_state == IDLE);

    assign w_src_a = (bus.alu_src_a_d && !bus.md_en_d) ? DATA_WIDTH'(bus.pc_d) : bus.rd1_d;
    assign w_src_b = (bus.alu_src_b_d && !bus.md_en_d) ? bus.imm_val_d : bus.rd2_d;
    assign w_shamt = w_src_b[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (bus.alu_control_d)
            ALU_ADD:   w_alu = w_src_a + w_src_b;
            ALU_SUB:   w_alu = w_src_a - w_src_b;
            ALU_AND:   w_alu = w_src_a & w_src_b;
            ALU_OR:    w_alu = w_src_a | w_src_b;
            ALU_XOR:   w_alu = w_src_a ^ w_src_b;
            ALU_SLT:   w_alu = DATA_WIDTH'($signed(w_src_a) < $signed(w_src_b));
            ALU_SLTU:  w_alu = DATA_WIDTH'(w_src_a < w_src_b);
            ALU_SLL:   w_alu = w_src_a << w_shamt;
            ALU_SRL:   w_alu = w_src_a >> w_shamt;
            ALU_SRA:   w_alu = $unsigned($signed(w_src_a) >>> w_shamt);
            ALU_PASSB: w_alu = w_src_b;
            default:   w_alu = '0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (bus.funct3_d)
            BR_BEQ:  w_taken = (bus.rd1_d == bus.rd2_d);
            BR_BNE:  w_taken = (bus.rd1_d != bus.rd2_d);
            BR_BLT:  w_taken = ($signed(bus.rd1_d) < $signed(bus.rd2_d));
            BR_BGE:  w_taken = ($signed(bus.rd1_d) >= $signed(bus.rd2_d));
            BR_BLTU: w_taken = (bus.rd1_d < bus.rd2_d);
            BR_BGEU: w_taken = (bus.rd1_d >= bus.rd2_d);
            default: w_taken = 1'b0;
        endcase
    end

    // Operands sign- or zero-extended to the full product width; the low 2*DATA_WIDTH bits
    // of the modular product are then exact for every signedness combination.
    assign w_mul_a = {{(DATA_WIDTH + 2){(bus.funct3_d == F3_MULH || bus.funct3_d == F3_MULHSU)
                                        && bus.rd1_d[DATA_WIDTH-1]}}, bus.rd1_d};
    assign w_mul_b = {{(DATA_WIDTH + 2){(bus.funct3_d == F3_MULH) && bus.rd2_d[DATA_WIDTH-1]}},
                      bus.rd2_d};
    assign w_prod  = w_mul_a * w_mul_b;

    assign w_min        = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    assign w_div_op     = bus.md_en_d && bus.funct3_d[2];
    assign w_div_signed = ~bus.funct3_d[0];
    assign w_div_zero   = (bus.rd2_d == '0);
    assign w_div_ovf    = w_div_signed && (bus.rd1_d == w_min) && (bus.rd2_d == '1);
    assign w_div_start  = w_transfer && w_div_op && !w_div_zero && !w_div_ovf;

    always_comb begin
        w_md = '0;
        case (bus.funct3_d)
            F3_MUL:                        w_md = w_prod[DATA_WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  w_md = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            default: begin
                if (w_div_zero)     w_md = bus.funct3_d[1] ? bus.rd1_d : '1;
                else if (w_div_ovf) w_md = bus.funct3_d[1] ? '0 : w_min;
            end
        endcase
    end

    assign w_result = bus.md_en_d ? w_md : w_alu;

    md_divider #(.DATA_WIDTH(DATA_WIDTH)) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_signed   (w_div_signed),
        .i_rem      (bus.funct3_d[1]),
        .i_dividend (bus.rd1_d),
        .i_divisor  (bus.rd2_d),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_result   (w_div_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            bus.valid_e      <= 1'b0;
            bus.reg_write_e  <= 1'b0;
            bus.mem_write_e  <= 1'b0;
            bus.pc_src_e     <= 1'b0;
            bus.res_src_e    <= '0;
            bus.funct3_e     <= '0;
            bus.rd_e         <= '0;
            bus.tid_e        <= '0;
            bus.alu_result_e <= '0;
            bus.write_data_e <= '0;
            bus.pc_target_e  <= '0;
            bus.pc_plus4_e   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    bus.valid_e <= w_transfer && !w_div_start;
                    if (w_transfer) begin
                        // Control for a long divide is parked in the _e regs while valid_e=0.
                        bus.reg_write_e  <= bus.reg_write_d;
                        bus.mem_write_e  <= bus.mem_write_d;
                        bus.pc_src_e     <= !bus.md_en_d && (bus.jump_d || (bus.branch_d && w_taken));
                        bus.res_src_e    <= bus.res_src_d;
                        bus.funct3_e     <= bus.funct3_d;
                        bus.rd_e         <= bus.rd_d;
                        bus.tid_e        <= bus.tid_d;
                        bus.write_data_e <= bus.rd2_d;
                        bus.pc_plus4_e   <= bus.pc_plus4_d;
                        bus.alu_result_e <= w_result;
                        bus.pc_target_e  <= ADDRESS_WIDTH'(w_result);
                        if (w_div_start) r_state <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    bus.valid_e <= w_div_done;
                    if (w_div_done || !w_div_busy) r_state <= IDLE;
                    if (w_div_done) begin
                        bus.alu_result_e <= w_div_result;
                        bus.pc_target_e  <= ADDRESS_WIDTH'(w_div_result);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_execute_md_mt.sv
// Directed bench for execute_md_mt: ALU, branches, multiply, divide latency, divide special
// cases, back-to-back issue and reset in the middle of a divide.
module tb_execute_md_mt;
    import riscv_pkg::*;

    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    execute_md_mt_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(32), .NUM_THREADS(4)) bus ();

    execute_md_mt #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(32), .NUM_THREADS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
        bus.valid_d = 1'b0;
    endtask

    task automatic set_op(input logic md, input logic [3:0] aluc, input logic [2:0] f3,
                          input logic sa, input logic sb, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                          input logic [1:0] tid);
        bus.valid_d       = 1'b1;
        bus.md_en_d       = md;
        bus.alu_control_d = aluc;
        bus.funct3_d      = f3;
        bus.alu_src_a_d   = sa;
        bus.alu_src_b_d   = sb;
        bus.rd1_d         = a;
        bus.rd2_d         = b;
        bus.imm_val_d     = imm;
        bus.pc_d          = pc;
        bus.pc_plus4_d    = pc + 32'd4;
        bus.tid_d         = tid;
        bus.rd_d          = 5'd1 + 5'(tid);
        bus.reg_write_d   = 1'b1;
        bus.mem_write_d   = 1'b0;
        bus.jump_d        = 1'b0;
        bus.branch_d      = 1'b0;
        bus.res_src_d     = 2'd0;
    endtask

    task automatic test_reset();
        set_op(1'b0, ALU_ADD, 3'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 2'd0);
        bus.valid_d = 1'b0;
        rst = 1'b1;
        step();
        step();
        n_checks += 3;
        if (bus.valid_e !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid got %b want 0", bus.valid_e);
        end
        if (bus.ready_d !== 1'b1) begin
            n_errors++; $display("FAIL reset_ready got %b want 1", bus.ready_d);
        end
        if ({bus.alu_result_e, bus.tid_e, bus.pc_src_e, bus.pc_target_e} !== '0) begin
            n_errors++; $display("FAIL reset_regs got %h/%h want 0", bus.alu_result_e,
                                 bus.pc_target_e);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        set_op(1'b0, ALU_ADD, 3'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 32'h40, 2'd2);
        step();
        n_checks += 4;
        if (bus.valid_e !== 1'b1) begin
            n_errors++; $display("FAIL add_valid got %b want 1", bus.valid_e);
        end
        if (bus.alu_result_e !== 32'd12) begin
            n_errors++; $display("FAIL add_result got %h want 0000000c", bus.alu_result_e);
        end
        if (bus.tid_e !== 2'd2 || bus.rd_e !== 5'd3) begin
            n_errors++; $display("FAIL add_tid_rd got %0d/%0d want 2/3", bus.tid_e, bus.rd_e);
        end
        if (bus.write_data_e !== 32'd7 || bus.pc_plus4_e !== 32'h44) begin
            n_errors++; $display("FAIL add_pass got %h/%h want 7/44", bus.write_data_e,
                                 bus.pc_plus4_e);
        end
        step();
        n_checks += 2;
        if (bus.valid_e !== 1'b0) begin
            n_errors++; $display("FAIL add_drop got %b want 0", bus.valid_e);
        end
        if (bus.alu_result_e !== 32'd12) begin
            n_errors++; $display("FAIL add_hold got %h want 0000000c", bus.alu_result_e);
        end
    endtask

    task automatic test_branch();
        set_op(1'b0, ALU_ADD, BR_BEQ, 1'b1, 1'b1, 32'd3, 32'd3, 32'h20, 32'h100, 2'd0);
        bus.branch_d = 1'b1;
        step();
        n_checks += 2;
        if (bus.pc_src_e !== 1'b1) begin
            n_errors++; $display("FAIL beq_taken got %b want 1", bus.pc_src_e);
        end
        if (bus.pc_target_e !== 32'h120) begin
            n_errors++; $display("FAIL beq_target got %h want 00000120", bus.pc_target_e);
        end
        set_op(1'b0, ALU_ADD, BR_BEQ, 1'b1, 1'b1, 32'd3, 32'd4, 32'h20, 32'h100, 2'd0);
        bus.branch_d = 1'b1;
        step();
        n_checks += 2;
        if (bus.pc_src_e !== 1'b0 || bus.valid_e !== 1'b1) begin
            n_errors++; $display("FAIL beq_not_taken got %b want 0", bus.pc_src_e);
        end
        if (bus.pc_target_e !== 32'h120) begin
            n_errors++; $display("FAIL beq_nt_target got %h want 00000120", bus.pc_target_e);
        end
        set_op(1'b0, ALU_ADD, BR_BLT, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h200, 2'd0);
        bus.branch_d = 1'b1;
        step();
        n_checks++;
        if (bus.pc_src_e !== 1'b1 || bus.pc_target_e !== 32'h208) begin
            n_errors++; $display("FAIL blt_signed got %b/%h want 1/00000208", bus.pc_src_e,
                                 bus.pc_target_e);
        end
    endtask

    task automatic test_mul();
        logic [2:0]  f3  [4] = '{F3_MULH, F3_MULHSU, F3_MULHU, F3_MUL};
        logic [31:0] a   [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
        logic [31:0] b   [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
        logic [31:0] exp [4] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFF4};
        for (int i = 0; i < 4; i++) begin
            // alu_src and jump set on purpose: M ops must ignore both.
            set_op(1'b1, ALU_SUB, f3[i], 1'b1, 1'b1, a[i], b[i], 32'h55, 32'h300, 2'd1);
            bus.jump_d = 1'b1;
            step();
            n_checks += 2;
            if (bus.valid_e !== 1'b1 || bus.alu_result_e !== exp[i]) begin
                n_errors++; $display("FAIL mul_%0d got %h want %h", i, bus.alu_result_e, exp[i]);
            end
            if (bus.pc_src_e !== 1'b0 || bus.ready_d !== 1'b1) begin
                n_errors++; $display("FAIL mul_pcsrc_%0d got %b want 0", i, bus.pc_src_e);
            end
        end
    endtask

    task automatic run_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input logic [1:0] tid, input string name);
        int k = 0;
        int busy_bad = 0;
        set_op(1'b1, ALU_ADD, f3, 1'b0, 1'b0, a, b, 32'd0, 32'd0, tid);
        step();
        while (k < 50 && bus.valid_e !== 1'b1) begin
            if (bus.ready_d !== 1'b0) busy_bad++;
            step();
            k++;
        end
        n_checks += 4;
        if (k !== DW + 1) begin
            n_errors++; $display("FAIL %s_latency got %0d want %0d", name, k, DW + 1);
        end
        if (busy_bad !== 0) begin
            n_errors++; $display("FAIL %s_stall got %0d ready-high cycles want 0", name, busy_bad);
        end
        if (bus.alu_result_e !== exp || bus.tid_e !== tid) begin
            n_errors++; $display("FAIL %s_result got %h/%0d want %h/%0d", name, bus.alu_result_e,
                                 bus.tid_e, exp, tid);
        end
        if (bus.ready_d !== 1'b1) begin
            n_errors++; $display("FAIL %s_ready got %b want 1", name, bus.ready_d);
        end
        step();
        n_checks++;
        if (bus.valid_e !== 1'b0) begin
            n_errors++; $display("FAIL %s_pulse got %b want 0", name, bus.valid_e);
        end
    endtask

    task automatic test_div();
        run_div(F3_DIV,  32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD, 2'd1, "div");
        run_div(F3_REM,  32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, 2'd3, "rem");
        run_div(F3_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 2'd0, "divu");
        run_div(F3_REMU, 32'd100,       32'd7,  32'd2,         2'd2, "remu");
    endtask

    task automatic test_div_special();
        logic [2:0]  f3  [4] = '{F3_DIV, F3_REMU, F3_DIV, F3_REM};
        logic [31:0] a   [4] = '{32'd77, 32'd9, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd9, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            set_op(1'b1, ALU_ADD, f3[i], 1'b0, 1'b0, a[i], b[i], 32'd0, 32'd0, 2'd3);
            step();
            n_checks += 2;
            if (bus.valid_e !== 1'b1 || bus.alu_result_e !== exp[i]) begin
                n_errors++; $display("FAIL divspec_%0d got %h want %h", i, bus.alu_result_e,
                                     exp[i]);
            end
            if (bus.ready_d !== 1'b1) begin
                n_errors++; $display("FAIL divspec_ready_%0d got %b want 1", i, bus.ready_d);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_op(1'b0, ALU_SUB, 3'd0, 1'b0, 1'b0, 32'd10, 32'd3, 32'd0, 32'd0, 2'd0);
        step();
        set_op(1'b0, ALU_SLL, 3'd0, 1'b0, 1'b1, 32'd3, 32'd0, 32'd4, 32'd0, 2'd1);
        n_checks++;
        if (bus.valid_e !== 1'b1 || bus.alu_result_e !== 32'd7) begin
            n_errors++; $display("FAIL b2b_first got %h want 00000007", bus.alu_result_e);
        end
        step();
        n_checks++;
        if (bus.valid_e !== 1'b1 || bus.alu_result_e !== 32'd48 || bus.tid_e !== 2'd1) begin
            n_errors++; $display("FAIL b2b_second got %h want 00000030", bus.alu_result_e);
        end
    endtask

    task automatic test_reset_mid_div();
        int highs = 0;
        set_op(1'b1, ALU_ADD, F3_DIVU, 1'b0, 1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 2'd3);
        step();
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks += 2;
        if (bus.valid_e !== 1'b0) begin
            n_errors++; $display("FAIL abort_valid got %b want 0", bus.valid_e);
        end
        if (bus.ready_d !== 1'b1) begin
            n_errors++; $display("FAIL abort_ready got %b want 1", bus.ready_d);
        end
        repeat (40) begin
            step();
            if (bus.valid_e !== 1'b0) highs++;
        end
        n_checks++;
        if (highs !== 0) begin
            n_errors++; $display("FAIL abort_ghost got %0d valid cycles want 0", highs);
        end
        set_op(1'b0, ALU_ADD, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 2'd2);
        step();
        n_checks++;
        if (bus.valid_e !== 1'b1 || bus.alu_result_e !== 32'd3 || bus.tid_e !== 2'd2) begin
            n_errors++; $display("FAIL abort_followup got %h want 00000003", bus.alu_result_e);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_mul();
        test_div();
        test_div_special();
        test_back_to_back();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
